// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux between requesters A (X side) and B (Y side).
// A granted requester may burst up to MAX_BURST words into a single registered output stage.
//
// state | meaning
// IDLE  | no owner, sel holds its last value
// OWN_A | A owns the datapath, sel=1
// OWN_B | B owns the datapath, sel=0
module mux_rr_arbiter #(
  parameter int W         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a_data,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [W-1:0] b_data,
  input  logic         b_valid,
  output logic         b_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         sel,
  output logic         busy
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t         r_state;
  logic           r_m_valid;
  logic [W-1:0]   r_m_data;
  logic           r_sel;
  logic [CW-1:0]  r_burst_cnt;
  logic           r_last_a;

  logic w_load_ok;
  logic w_a_xfer;
  logic w_b_xfer;
  logic w_burst_end;

  assign w_load_ok   = !r_m_valid || m_ready;
  assign a_ready     = (r_state == OWN_A) && w_load_ok;
  assign b_ready     = (r_state == OWN_B) && w_load_ok;
  assign w_a_xfer    = a_valid && a_ready;
  assign w_b_xfer    = b_valid && b_ready;
  assign w_burst_end = (r_burst_cnt == BURST_LAST);

  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign sel     = r_sel;
  assign busy    = (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_sel       <= 1'b0;
      r_burst_cnt <= '0;
      r_last_a    <= 1'b0;
    end else begin
      if (w_load_ok) begin
        r_m_valid <= w_a_xfer || w_b_xfer;
        if (w_a_xfer)      r_m_data <= a_data;
        else if (w_b_xfer) r_m_data <= b_data;
      end

      case (r_state)
        IDLE: begin
          // on a tie, grant whichever side was not served last
          if (a_valid && (!b_valid || !r_last_a)) begin
            r_state     <= OWN_A;
            r_sel       <= 1'b1;
            r_burst_cnt <= '0;
          end else if (b_valid) begin
            r_state     <= OWN_B;
            r_sel       <= 1'b0;
            r_burst_cnt <= '0;
          end
        end

        OWN_A: begin
          if ((w_a_xfer && w_burst_end) || (!a_valid && w_load_ok)) begin
            r_last_a    <= 1'b1;
            r_burst_cnt <= '0;
            if (b_valid) begin
              r_state <= OWN_B;
              r_sel   <= 1'b0;
            end else if (!a_valid) begin
              r_state <= IDLE;
            end
          end else if (w_a_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end

        OWN_B: begin
          if ((w_b_xfer && w_burst_end) || (!b_valid && w_load_ok)) begin
            r_last_a    <= 1'b0;
            r_burst_cnt <= '0;
            if (a_valid) begin
              r_state <= OWN_A;
              r_sel   <= 1'b1;
            end else if (!b_valid) begin
              r_state <= IDLE;
            end
          end else if (w_b_xfer) begin
            r_burst_cnt <= r_burst_cnt + CW'(1);
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
